// File: rtl/lbp_io_pkg.sv
// Shared constants and channel state type for the LBP pad I/O sequencer.
// Optional feature macro: LBP_IO_BACKTOBACK_EN (see qtr_beat_seq).
package lbp_io_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int BEATS  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } chan_state_e;

endpackage

// File: rtl/lbp_io_ctrl_qtr_beat_seq.sv
// One pad channel: IDLE/SEND state, 2-bit beat counter, ready and strobe.
// LBP_IO_BACKTOBACK_EN lets a new transfer be accepted on the last beat.
module qtr_beat_seq
  import lbp_io_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       hold,
  output logic       ready,
  output logic       accept,
  output logic       strobe,
  output logic       done,
  output logic [1:0] count
);

  chan_state_e state;
  logic [1:0]  beat;
  logic        last;

  assign strobe = (state == SEND);
  assign last   = strobe && (beat == 2'(BEATS - 1));
  assign count  = strobe ? beat : 2'd0;

`ifdef LBP_IO_BACKTOBACK_EN
  assign ready = !hold && (!strobe || last);
`else
  assign ready = !hold && !strobe;
`endif

  assign accept = req && ready;

  // done marks the cycle after the last beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      beat  <= 2'd0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        state <= SEND;
        beat  <= 2'd0;
      end else if (strobe) begin
        beat <= beat + 2'd1;
        if (last) state <= IDLE;
      end
    end
  end

endmodule

// File: rtl/lbp_io_ctrl.sv
// LBP pad I/O sequencer: operand hold, gray capture, finish gating.
// Build option LBP_IO_BACKTOBACK_EN removes the idle gap between transfers.
module lbp_io_ctrl #(
  parameter int ADDR_W = lbp_io_pkg::ADDR_W,
  parameter int DATA_W = lbp_io_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_req_addr,
  output logic              gray_req_ready,
  output logic [ADDR_W-1:0] gray_addr,
  output logic [1:0]        gray_count,
  output logic              gray_addr_valid,
  input  logic [DATA_W-1:0] gray_data,
  output logic [DATA_W-1:0] gray_rdata,
  output logic              gray_rvalid,
  input  logic              lbp_req,
  input  logic [ADDR_W-1:0] lbp_req_addr,
  input  logic [DATA_W-1:0] lbp_req_data,
  output logic              lbp_req_ready,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [DATA_W-1:0] lbp_data,
  output logic [1:0]        lbp_count,
  output logic              lbp_valid,
  output logic              lbp_done,
  input  logic              finish_req,
  output logic              finish
);

  logic g_accept;
  logic g_flag;
  logic l_accept;
  logic fin_pend;
  logic hold;

  assign hold = fin_pend || finish;

  qtr_beat_seq u_gray (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (gray_req),
    .hold   (hold),
    .ready  (gray_req_ready),
    .accept (g_accept),
    .strobe (gray_addr_valid),
    .done   (g_flag),
    .count  (gray_count)
  );

  qtr_beat_seq u_lbp (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (lbp_req),
    .hold   (hold),
    .ready  (lbp_req_ready),
    .accept (l_accept),
    .strobe (lbp_valid),
    .done   (lbp_done),
    .count  (lbp_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gray_addr <= '0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
    end else begin
      if (g_accept) gray_addr <= gray_req_addr;
      if (l_accept) begin
        lbp_addr <= lbp_req_addr;
        lbp_data <= lbp_req_data;
      end
    end
  end

  // pad data is sampled purely on the end flag, independent of state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gray_rdata  <= '0;
      gray_rvalid <= 1'b0;
    end else begin
      gray_rvalid <= g_flag;
      if (g_flag) gray_rdata <= gray_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fin_pend <= 1'b0;
      finish   <= 1'b0;
    end else begin
      fin_pend <= fin_pend || finish_req;
      finish   <= finish || (fin_pend && !gray_addr_valid
                  && !lbp_valid && !g_flag);
    end
  end

endmodule

// File: tb/tb_lbp_io_ctrl.sv
// Randomized self-checking bench for lbp_io_ctrl with a timeline model.
// Honours LBP_IO_BACKTOBACK_EN in the model's ready rule.
module tb_lbp_io_ctrl;

  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          gray_req = 1'b0;
  logic [AW-1:0] gray_req_addr = '0;
  logic          gray_req_ready;
  logic [AW-1:0] gray_addr;
  logic [1:0]    gray_count;
  logic          gray_addr_valid;
  logic [DW-1:0] gray_data = '0;
  logic [DW-1:0] gray_rdata;
  logic          gray_rvalid;
  logic          lbp_req = 1'b0;
  logic [AW-1:0] lbp_req_addr = '0;
  logic [DW-1:0] lbp_req_data = '0;
  logic          lbp_req_ready;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic [1:0]    lbp_count;
  logic          lbp_valid;
  logic          lbp_done;
  logic          finish_req = 1'b0;
  logic          finish;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lbp_io_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .gray_req       (gray_req),
    .gray_req_addr  (gray_req_addr),
    .gray_req_ready (gray_req_ready),
    .gray_addr      (gray_addr),
    .gray_count     (gray_count),
    .gray_addr_valid(gray_addr_valid),
    .gray_data      (gray_data),
    .gray_rdata     (gray_rdata),
    .gray_rvalid    (gray_rvalid),
    .lbp_req        (lbp_req),
    .lbp_req_addr   (lbp_req_addr),
    .lbp_req_data   (lbp_req_data),
    .lbp_req_ready  (lbp_req_ready),
    .lbp_addr       (lbp_addr),
    .lbp_data       (lbp_data),
    .lbp_count      (lbp_count),
    .lbp_valid      (lbp_valid),
    .lbp_done       (lbp_done),
    .finish_req     (finish_req),
    .finish         (finish)
  );

  logic [10:0] dut_ctrl;
  assign dut_ctrl = {gray_req_ready, lbp_req_ready, gray_addr_valid,
                     lbp_valid, gray_rvalid, lbp_done, finish,
                     gray_count, lbp_count};

  // Model: accept cycles per channel; everything else follows from them.
  int            g_acc[$];
  logic [AW-1:0] g_aq[$];
  int            l_acc[$];
  logic [AW-1:0] l_aq[$];
  logic [DW-1:0] l_dq[$];
  logic [DW-1:0] gd[0:4095];
  int            pend_from = BIG;

  function automatic int g_idx(input int c);
    for (int i = g_acc.size() - 1; i >= 0; i--)
      if (c > g_acc[i] && c <= g_acc[i] + 4) return i;
    return -1;
  endfunction

  function automatic int l_idx(input int c);
    for (int i = l_acc.size() - 1; i >= 0; i--)
      if (c > l_acc[i] && c <= l_acc[i] + 4) return i;
    return -1;
  endfunction

  function automatic int g_beat(input int c);
    int i;
    i = g_idx(c);
    return (i < 0) ? -1 : c - g_acc[i] - 1;
  endfunction

  function automatic int l_beat(input int c);
    int i;
    i = l_idx(c);
    return (i < 0) ? -1 : c - l_acc[i] - 1;
  endfunction

  function automatic bit hit(input int q[$], input int c, input int d);
    foreach (q[i]) if (q[i] + d == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready(input int beat, input int c);
    if (c >= pend_from) return 1'b0;
`ifdef LBP_IO_BACKTOBACK_EN
    return beat < 0 || beat == 3;
`else
    return beat < 0;
`endif
  endfunction

  function automatic bit m_fin(input int c);
    for (int k = pend_from; k < c; k++)
      if (g_idx(k) < 0 && l_idx(k) < 0 && !hit(g_acc, k, 5))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [10:0] e_ctrl(input int c);
    int gb;
    int lb;
    gb = g_beat(c);
    lb = l_beat(c);
    return {m_ready(gb, c), m_ready(lb, c), gb >= 0, lb >= 0,
            hit(g_acc, c, 6), hit(l_acc, c, 5), m_fin(c),
            (gb < 0) ? 2'd0 : 2'(gb), (lb < 0) ? 2'd0 : 2'(lb)};
  endfunction

  task automatic tick(input bit rn, input bit gr, input logic [AW-1:0] ga,
                      input bit lr, input logic [AW-1:0] la,
                      input logic [DW-1:0] ld, input bit fr,
                      input logic [DW-1:0] gdat);
    bit rg;
    bit rl;
    @(posedge clk);
    #1;
    reset_n = rn;
    gray_req = gr;
    gray_req_addr = ga;
    lbp_req = lr;
    lbp_req_addr = la;
    lbp_req_data = ld;
    finish_req = fr;
    gray_data = gdat;
    gd[cyc] = gdat;
    if (!rn) begin
      g_acc.delete();
      g_aq.delete();
      l_acc.delete();
      l_aq.delete();
      l_dq.delete();
      pend_from = BIG;
    end else begin
      rg = m_ready(g_beat(cyc), cyc);
      rl = m_ready(l_beat(cyc), cyc);
      if (gr && rg) begin
        g_acc.push_back(cyc);
        g_aq.push_back(ga);
      end
      if (lr && rl) begin
        l_acc.push_back(cyc);
        l_aq.push_back(la);
        l_dq.push_back(ld);
      end
      if (fr && pend_from == BIG) pend_from = cyc + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, '0, 0, '0, '0, 0, '0);
      checks++;
      if (dut_ctrl !== 11'b11000000000) begin
        errors++;
        $display("FAIL reset_ctrl cyc=%0d got=%b exp=%b", cyc, dut_ctrl,
                 11'b11000000000);
      end
      checks++;
      if ({gray_addr, lbp_addr, lbp_data, gray_rdata} !== '0) begin
        errors++;
        $display("FAIL reset_data cyc=%0d got=%h/%h/%h/%h exp=0", cyc,
                 gray_addr, lbp_addr, lbp_data, gray_rdata);
      end
    end
    tick(1, 0, '0, 0, '0, '0, 0, '0);
    checks++;
    if (dut_ctrl !== e_ctrl(cyc)) begin
      errors++;
      $display("FAIL release_ctrl cyc=%0d got=%b exp=%b", cyc, dut_ctrl,
               e_ctrl(cyc));
    end
  endtask

  task automatic test_gray_read();
    int t0;
    tick(1, 1, 14'h2A5C, 0, '0, '0, 0, 8'($urandom));
    t0 = cyc;
    for (int i = 1; i <= 7; i++) begin
      tick(1, 0, '0, 0, '0, '0, 0,
           (cyc + 1 == t0 + 5) ? 8'h7E : 8'($urandom));
      checks++;
      if (dut_ctrl !== e_ctrl(cyc)) begin
        errors++;
        $display("FAIL gray_ctrl cyc=%0d got=%b exp=%b", cyc, dut_ctrl,
                 e_ctrl(cyc));
      end
      if (i <= 4) begin
        checks++;
        if (gray_count !== 2'(i - 1) || gray_addr_valid !== 1'b1
            || gray_addr !== 14'h2A5C) begin
          errors++;
          $display("FAIL gray_beat i=%0d got=%0d/%b/%h exp=%0d/1/2a5c", i,
                   gray_count, gray_addr_valid, gray_addr, i - 1);
        end
      end
      if (i == 6) begin
        checks++;
        if (gray_rvalid !== 1'b1 || gray_rdata !== 8'h7E) begin
          errors++;
          $display("FAIL gray_rdata got=%b/%h exp=1/7e", gray_rvalid,
                   gray_rdata);
        end
      end
    end
  endtask

  task automatic test_lbp_write();
    int t0;
    tick(1, 0, '0, 1, 14'h3FFF, 8'hB4, 0, 8'($urandom));
    t0 = cyc;
    for (int i = 1; i <= 6; i++) begin
      tick(1, 0, '0, 0, '0, '0, 0, 8'($urandom));
      checks++;
      if (dut_ctrl !== e_ctrl(cyc)) begin
        errors++;
        $display("FAIL lbp_ctrl cyc=%0d got=%b exp=%b", cyc, dut_ctrl,
                 e_ctrl(cyc));
      end
      if (i <= 4) begin
        checks++;
        if (lbp_count !== 2'(i - 1) || lbp_valid !== 1'b1
            || lbp_addr !== 14'h3FFF || lbp_data !== 8'hB4) begin
          errors++;
          $display("FAIL lbp_beat i=%0d got=%0d/%b/%h/%h exp=%0d/1/3fff/b4",
                   i, lbp_count, lbp_valid, lbp_addr, lbp_data, i - 1);
        end
      end
      checks++;
      if (lbp_done !== (cyc == t0 + 5)) begin
        errors++;
        $display("FAIL lbp_done i=%0d got=%b exp=%b", i, lbp_done,
                 cyc == t0 + 5);
      end
    end
  endtask

  task automatic test_concurrent();
    int gi;
    int li;
    for (int i = 0; i < 160; i++) begin
      tick(1, i < 60 || $urandom_range(0, 2) != 0, AW'($urandom),
           i < 60 || $urandom_range(0, 2) != 0, AW'($urandom),
           DW'($urandom), 0, DW'($urandom));
      gi = g_idx(cyc);
      li = l_idx(cyc);
      checks++;
      if (dut_ctrl !== e_ctrl(cyc)) begin
        errors++;
        $display("FAIL conc_ctrl cyc=%0d got=%b exp=%b", cyc, dut_ctrl,
                 e_ctrl(cyc));
      end
      if (gi >= 0) begin
        checks++;
        if (gray_addr !== g_aq[gi]) begin
          errors++;
          $display("FAIL conc_gaddr cyc=%0d got=%h exp=%h", cyc,
                   gray_addr, g_aq[gi]);
        end
      end
      if (li >= 0) begin
        checks++;
        if (lbp_addr !== l_aq[li] || lbp_data !== l_dq[li]) begin
          errors++;
          $display("FAIL conc_lbp cyc=%0d got=%h/%h exp=%h/%h", cyc,
                   lbp_addr, lbp_data, l_aq[li], l_dq[li]);
        end
      end
      if (hit(g_acc, cyc, 6)) begin
        checks++;
        if (gray_rdata !== gd[cyc-1]) begin
          errors++;
          $display("FAIL conc_rdata cyc=%0d got=%h exp=%h", cyc,
                   gray_rdata, gd[cyc-1]);
        end
      end
    end
  endtask

  task automatic test_finish();
    int t0;
    for (int i = 0; i < 8; i++)
      tick(1, 0, '0, 0, '0, '0, 0, 8'($urandom));
    tick(1, 0, '0, 1, 14'h1234, 8'h5A, 0, 8'($urandom));
    t0 = cyc;
    for (int i = 1; i <= 12; i++) begin
      tick(1, i >= 3, AW'($urandom), i >= 3, AW'($urandom),
           DW'($urandom), i == 2, 8'($urandom));
      checks++;
      if (dut_ctrl !== e_ctrl(cyc)) begin
        errors++;
        $display("FAIL fin_ctrl cyc=%0d got=%b exp=%b", cyc, dut_ctrl,
                 e_ctrl(cyc));
      end
      checks++;
      if (finish !== (i >= 6) || lbp_done !== (i == 5)
          || lbp_valid !== (i <= 4) || gray_addr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fin_seq i=%0d got=%b/%b/%b/%b exp=%b/%b/%b/0", i,
                 finish, lbp_done, lbp_valid, gray_addr_valid, i >= 6,
                 i == 5, i <= 4);
      end
      if (i >= 3) begin
        checks++;
        if (gray_req_ready !== 1'b0 || lbp_req_ready !== 1'b0) begin
          errors++;
          $display("FAIL fin_ready i=%0d got=%b/%b exp=0/0", i,
                   gray_req_ready, lbp_req_ready);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int t0;
    tick(0, 0, '0, 0, '0, '0, 0, '0);
    tick(1, 0, '0, 0, '0, '0, 0, '0);
    tick(1, 1, 14'h0ABC, 0, '0, '0, 0, 8'($urandom));
    t0 = cyc;
    for (int i = 1; i <= 2; i++) begin
      tick(1, 0, '0, 0, '0, '0, 0, 8'($urandom));
      checks++;
      if (gray_count !== 2'(i - 1) || dut_ctrl !== e_ctrl(cyc)) begin
        errors++;
        $display("FAIL mid_beat i=%0d got=%b exp=%b", i, dut_ctrl,
                 e_ctrl(cyc));
      end
    end
    tick(0, 0, '0, 0, '0, '0, 0, 8'($urandom));
    checks++;
    if (dut_ctrl !== 11'b11000000000 || gray_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset cyc=%0d got=%b/%h exp=11000000000/0", cyc,
               dut_ctrl, gray_addr);
    end
    tick(0, 0, '0, 0, '0, '0, 0, 8'($urandom));
    for (int i = 0; i < 6; i++) begin
      tick(1, 0, '0, 0, '0, '0, 0, 8'($urandom));
      checks++;
      if (gray_rvalid !== 1'b0 || dut_ctrl !== e_ctrl(cyc)) begin
        errors++;
        $display("FAIL mid_norv cyc=%0d got=%b exp=%b", cyc, dut_ctrl,
                 e_ctrl(cyc));
      end
    end
    tick(1, 1, 14'h1555, 0, '0, '0, 0, 8'($urandom));
    t0 = cyc;
    for (int i = 1; i <= 7; i++) begin
      tick(1, 0, '0, 0, '0, '0, 0,
           (cyc + 1 == t0 + 5) ? 8'hC3 : 8'($urandom));
      checks++;
      if (dut_ctrl !== e_ctrl(cyc)) begin
        errors++;
        $display("FAIL mid_new cyc=%0d got=%b exp=%b", cyc, dut_ctrl,
                 e_ctrl(cyc));
      end
      if (i == 6) begin
        checks++;
        if (gray_rvalid !== 1'b1 || gray_rdata !== 8'hC3) begin
          errors++;
          $display("FAIL mid_rdata got=%b/%h exp=1/c3", gray_rvalid,
                   gray_rdata);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_gray_read();
    test_lbp_write();
    test_concurrent();
    test_finish();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lbp_io_ctrl.md
# lbp_io_ctrl

Sequencer for the LBP chip's pin-reduced I/O path. It accepts gray-read requests and LBP-write requests from the core, holds each address/data word stable, and steps the 2-bit beat counters that drive the quarter-slicing datapath: 4 nibble beats per address, 2-bit slices for LBP data. It also captures returned gray data and gates the final `finish` until every transfer has drained. It sits between the LBP core FSM and the quarter-slicing datapath at the pads.

## Interface
Parameters:
- ADDR_W, 14, full pixel address width
- DATA_W, 8, gray/LBP data width
- BEATS, 4, beats per transfer (fixed; counter width 2)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- gray_req  in  1  core gray-read request (valid)
- gray_req_addr  in  ADDR_W  address, sampled on accept
- gray_req_ready  out  1  controller can accept gray request
- gray_addr  out  ADDR_W  held address to slicer
- gray_count  out  2  gray beat index to slicer
- gray_addr_valid  out  1  pad strobe, high during gray beats
- gray_data  in  DATA_W  pad return data
- gray_rdata  out  DATA_W  registered returned pixel
- gray_rvalid  out  1  one-cycle pulse, gray_rdata valid
- lbp_req  in  1  core LBP-write request
- lbp_req_addr  in  ADDR_W  write address
- lbp_req_data  in  DATA_W  write data
- lbp_req_ready  out  1  controller can accept LBP write
- lbp_addr / lbp_data  out  ADDR_W / DATA_W  held operands to slicer
- lbp_count  out  2  LBP beat index to slicer
- lbp_valid  out  1  pad strobe, high during LBP beats
- lbp_done  out  1  one-cycle pulse after last LBP beat
- finish_req  in  1  core has issued its last request
- finish  out  1  sticky chip finish to pad

## Operation
- The gray and LBP channels are independent and may be busy in the same cycle. Each channel has states IDLE and SEND, plus a 2-bit beat counter.
- Accept: req && ready at clock edge T. Operands are registered, state goes to SEND, and the beat is 0 at T+1.
- SEND: beat increments every cycle. After beat 3 the channel returns to IDLE, or see Configuration.
- The count output is the beat in SEND and 0 in IDLE. The strobe is high only in SEND.
- Held operands are stable from T+1 through beat 3. They are retained while IDLE.
- Gray return: a registered flag marks the cycle after beat 3. In that cycle gray_data is sampled into gray_rdata, and gray_rvalid pulses in the following cycle. Sampling depends only on the flag, not on state.
- lbp_done pulses in the cycle after beat 3.
- Finish: finish_req is latched into a pending bit. finish rises when the bit is set, both channels are IDLE, and no gray return is outstanding. finish is sticky until reset.
- Once finish is pending or set, both ready outputs are low.
- An lbp_req accepted in the same cycle finish_req is first seen is served. finish then waits for it to drain.
- Reset: all state goes to IDLE and all outputs go to 0, except that both readys are 1. An in-flight transfer is dropped with no done or rvalid pulse.

## Timing
- Gray latency: accept at T, beats T+1..T+4, pad data sampled at T+5, gray_rvalid at T+6.
- LBP latency: accept at T, beats T+1..T+4, lbp_done at T+5.
- Default throughput: ready is high only in IDLE, so transfers are spaced by one idle cycle (5 cycles per transfer).
- Ready outputs are combinational from state. Requests are never combinationally dependent on ready.

## Configuration
- LBP_IO_BACKTOBACK_EN defined: ready is also high during beat 3. An accept there goes straight to beat 0 of the next transfer (4 cycles per transfer, no gap). The gray return for transfer N overlaps beat 0 of transfer N+1.
- Not defined: default behaviour above, with one idle cycle between transfers.

## Structure
- Package lbp_io_pkg holds ADDR_W, DATA_W, the BEATS constant, and the channel state enum (IDLE, SEND).
- Sub-module qtr_beat_seq holds one channel's state, beat counter, ready, strobe and end-of-transfer flag. It is instantiated twice.
- The top level contains operand registers, gray capture and finish logic.

## Test plan
- Single gray read of address 0x2A5C, with gray_data=0x7E at T+5 -> gray_count 0,1,2,3 at T+1..T+4, strobe high on those cycles, gray_rdata=0x7E with rvalid at T+6.
- Single LBP write of addr 0x3FFF, data 0xB4 -> lbp_count 0..3, lbp_data held 0xB4, lbp_done at T+5.
- Continuous requests on both channels at once -> each channel is independent. Spacing is 5 cycles by default and 4 with LBP_IO_BACKTOBACK_EN, with gray_rdata matching per transfer.
- finish_req asserted during LBP beat 1 -> finish rises one cycle after the channels go idle and lbp_done fires. Readys are then 0 and later requests are ignored.
- reset_n dropped during gray beat 2 -> outputs are 0 immediately and no rvalid pulse occurs. After release, a new request completes normally.
